ahb_addr_decoder_mux: RTL and testbench
=======================================

// Module: ahb_addr_decoder_mux
// PURPOSE
// - Parametrised AHB decoder + subordinate-to-manager response mux for NO_OF_SLAVES subordinates.
// - Sits between one manager and N subordinate models; generates hselx and muxes hrdata/hreadyout/hresp.
// - Includes built-in default subordinate: two-cycle ERROR for unmapped addresses.
// - Generalises fixed 2-slave decode to N regions, with gap detection and an optional stall watchdog.
// PARAMETERS
// - NO_OF_SLAVES     2    number of subordinate regions (1..16)
// - ADDR_WIDTH       32   haddr width
// - DATA_WIDTH       32   hrdata width
// - SLAVE_MEMORY_SIZE 12  log2 bytes mapped per region
// - REGION_SHIFT     13   log2 region stride; slave i base = i<<REGION_SHIFT; must be >= SLAVE_MEMORY_SIZE
// - TIMEOUT_CYCLES   16   watchdog limit (used only with AHB_DECODER_TIMEOUT_EN), >=2
// PORTS
// - hclk         in   1                clock
// - hresetn      in   1                synchronous active-low reset
// - haddr        in   ADDR_WIDTH       manager address-phase address
// - htrans       in   2                IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
// - hselx        out  NO_OF_SLAVES     one-hot subordinate select (combinational from haddr)
// - hrdata_s     in   NO_OF_SLAVES*DATA_WIDTH  subordinate read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
// - hreadyout_s  in   NO_OF_SLAVES     subordinate hreadyout
// - hresp_s      in   NO_OF_SLAVES     subordinate hresp (0 OKAY, 1 ERROR)
// - hrdata       out  DATA_WIDTH       muxed read data to manager
// - hready       out  1                combined hready to manager and all subordinates
// - hresp        out  1                muxed response
// - timeout      out  1                one-cycle pulse on watchdog fire (port exists only with macro)
// BEHAVIOUR
// - Decode: idx = haddr>>REGION_SHIFT; hit when idx<NO_OF_SLAVES and haddr[REGION_SHIFT-1:0] < 2**SLAVE_MEMORY_SIZE.
//   hselx[idx] = hit, else all zero. hselx is independent of htrans.
// - Data-phase select register dsel (idx or NONE/DEFAULT) loads only when hready=1.
//   - Load hit idx if hit; DEFAULT if miss and htrans[1]=1; NONE otherwise.
// - Mux by dsel:
//   - slave i: hrdata/hready/hresp = hrdata_s[i]/hreadyout_s[i]/hresp_s[i].
//   - NONE: hrdata=0, hready=1, hresp=0.
//   - DEFAULT: driven by default FSM.
// - Default FSM: DS_IDLE -> DS_ERR1 when dsel loads DEFAULT.
//   - DS_ERR1: hready=0, hresp=1. -> DS_ERR2.
//   - DS_ERR2: hready=1, hresp=1. -> DS_ERR1 if another miss with htrans[1]=1, else DS_IDLE.
//   - hrdata=0 throughout.
// - Latency: zero added cycles for mapped slaves; unmapped NONSEQ/SEQ costs exactly 1 wait + 1 error-completion cycle.
// - IDLE/BUSY to unmapped address: zero-wait OKAY, no ERROR.
// - Reset (hresetn=0 at posedge):
//   - Clears dsel=NONE and FSM=DS_IDLE, even mid-transfer or mid-ERROR.
//   - Outputs become hready=1, hresp=0, hrdata=0; timeout=0.
//   - hselx still follows haddr.
// - Back-to-back: an address phase accepted in the final cycle of a slave's data phase switches dsel the next cycle; no bubble.
// CONFIGURATION
// - Macro AHB_DECODER_TIMEOUT_EN: adds the timeout port and a stall counter.
//   - Counter increments each cycle dsel=slave and hreadyout_s=0; clears on hready=1.
//   - At TIMEOUT_CYCLES it pulses timeout and forces the default ERROR sequence (ERR1, ERR2), ignoring that slave.
//   - It then returns dsel to NONE.
// - Without macro: no counter and no timeout port; a stalled slave stalls hready indefinitely.
// TESTING
// - Reset: hresetn=0 2 cycles -> hready=1, hresp=0, hrdata=0; haddr=0x0000_2000 -> hselx=2'b10.
// - Mapped read: NONSEQ haddr=0x0000_0010, hrdata_s[0]=0xDEAD_BEEF, hreadyout_s[0]=1 -> hselx=01; next cycle hrdata=0xDEADBEEF, hready=1, hresp=0.
// - Gap: NONSEQ haddr=0x0000_1004 (above 4KB) -> hselx=00; next cycle hready=0/hresp=1, then hready=1/hresp=1, then hready=1/hresp=0.
// - Wait-state pipelining: slave1 holds hreadyout_s[1]=0 3 cycles -> hready=0 3 cycles; address held, dsel unchanged; next NONSEQ to slave0 returns slave0 data with no bubble.
// - IDLE to unmapped 0xFFFF_0000 -> hresp=0, hready=1 every cycle.
// - Reset mid-ERR1 -> next cycle hready=1, hresp=0. With AHB_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=16: slave0 stalls 16 cycles -> timeout pulses once, then two-cycle ERROR.

Source files
------------

// File: rtl/ahb_addr_decoder_mux.sv
// AHB address decoder and subordinate response mux with a built-in ERROR subordinate.
// Optional stall watchdog enabled by defining AHB_DECODER_TIMEOUT_EN.
module ahb_addr_decoder_mux #(
    parameter int NO_OF_SLAVES      = 2,
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int SLAVE_MEMORY_SIZE = 12,
    parameter int REGION_SHIFT      = 13,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                               hclk,
    input  logic                               hresetn,
    input  logic [ADDR_WIDTH-1:0]              haddr,
    input  logic [1:0]                         htrans,
    output logic [NO_OF_SLAVES-1:0]            hselx,
    input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] hrdata_s,
    input  logic [NO_OF_SLAVES-1:0]            hreadyout_s,
    input  logic [NO_OF_SLAVES-1:0]            hresp_s,
    output logic [DATA_WIDTH-1:0]              hrdata,
    output logic                               hready,
`ifdef AHB_DECODER_TIMEOUT_EN
    output logic                               timeout,
`endif
    output logic                               hresp
);

    localparam int RW = ADDR_WIDTH - REGION_SHIFT;
    localparam logic [RW-1:0] N_REG = RW'(NO_OF_SLAVES);

    if (NO_OF_SLAVES < 1 || NO_OF_SLAVES > 16 ||
        REGION_SHIFT < SLAVE_MEMORY_SIZE || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("ahb_addr_decoder_mux: illegal parameters");
    end

    typedef enum logic [1:0] {SEL_NONE, SEL_SLAVE, SEL_DEFAULT} sel_t;
    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;

    sel_t                    dsel;
    ds_t                     ds;
    logic [3:0]              dslv;
    logic [3:0]              hit_idx;
    logic                    hit;
    logic [RW-1:0]           region;
    logic [REGION_SHIFT-1:0] offset;
    logic                    unused;

    assign unused = htrans[0];
    assign region = haddr[ADDR_WIDTH-1:REGION_SHIFT];
    assign offset = haddr[REGION_SHIFT-1:0];
    // Addresses past the mapped window but inside the stride fall in a gap.
    assign hit    = (region < N_REG) && ((offset >> SLAVE_MEMORY_SIZE) == '0);

    always_comb begin
        hselx   = '0;
        hit_idx = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (region == RW'(i)) begin
                hit_idx  = 4'(i);
                hselx[i] = hit;
            end
        end
    end

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b0;
        unique case (dsel)
            SEL_SLAVE: begin
                for (int i = 0; i < NO_OF_SLAVES; i++) begin
                    if (dslv == 4'(i)) begin
                        hrdata = hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
                        hready = hreadyout_s[i];
                        hresp  = hresp_s[i];
                    end
                end
            end
            SEL_DEFAULT: begin
                hready = (ds != DS_ERR1);
                hresp  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef AHB_DECODER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
`endif

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            dsel <= SEL_NONE;
            dslv <= '0;
            ds   <= DS_IDLE;
`ifdef AHB_DECODER_TIMEOUT_EN
            cnt     <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef AHB_DECODER_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            if (hready) begin
`ifdef AHB_DECODER_TIMEOUT_EN
                cnt <= '0;
`endif
                if (hit) begin
                    dsel <= SEL_SLAVE;
                    dslv <= hit_idx;
                    ds   <= DS_IDLE;
                end else if (htrans[1]) begin
                    dsel <= SEL_DEFAULT;
                    ds   <= DS_ERR1;
                end else begin
                    dsel <= SEL_NONE;
                    ds   <= DS_IDLE;
                end
            end else if (ds == DS_ERR1) begin
                ds <= DS_ERR2;
            end
`ifdef AHB_DECODER_TIMEOUT_EN
            // Only a stalled slave can hold hready low outside ERR1.
            else if (dsel == SEL_SLAVE) begin
                if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cnt     <= '0;
                    timeout <= 1'b1;
                    dsel    <= SEL_DEFAULT;
                    ds      <= DS_ERR1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ahb_addr_decoder_mux.sv
// Directed self-checking bench for ahb_addr_decoder_mux (2 slaves, default map).
// Exercises decode, gap ERROR, wait states, back-to-back errors and reset.
module tb_ahb_addr_decoder_mux;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [1:0]  hselx;
    logic [63:0] hrdata_s;
    logic [1:0]  hreadyout_s;
    logic [1:0]  hresp_s;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
`ifdef AHB_DECODER_TIMEOUT_EN
    logic        timeout;
`endif

    int pass_cnt = 0;
    int total    = 0;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    ahb_addr_decoder_mux dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .haddr       (haddr),
        .htrans      (htrans),
        .hselx       (hselx),
        .hrdata_s    (hrdata_s),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .hrdata      (hrdata),
        .hready      (hready),
`ifdef AHB_DECODER_TIMEOUT_EN
        .timeout     (timeout),
`endif
        .hresp       (hresp)
    );

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hresetn     = 1'b0;
        haddr       = 32'h0000_2000;
        htrans      = NONSEQ;
        hrdata_s    = {32'h1111_1111, 32'h2222_2222};
        hreadyout_s = 2'b11;
        hresp_s     = 2'b00;
        tick();
        tick();
        total++;
        if (hready !== 1'b1) $display("FAIL reset_hready: got %b expected 1", hready);
        else pass_cnt++;
        total++;
        if (hresp !== 1'b0) $display("FAIL reset_hresp: got %b expected 0", hresp);
        else pass_cnt++;
        total++;
        if (hrdata !== 32'h0) $display("FAIL reset_hrdata: got %h expected 0", hrdata);
        else pass_cnt++;
        total++;
        if (hselx !== 2'b10) $display("FAIL reset_hselx: got %b expected 10", hselx);
        else pass_cnt++;
        htrans  = IDLE;
        hresetn = 1'b1;
        tick();
    endtask

    task automatic test_mapped_read();
        haddr          = 32'h0000_0010;
        htrans         = NONSEQ;
        hrdata_s[31:0] = 32'hDEAD_BEEF;
        #1;
        total++;
        if (hselx !== 2'b01) $display("FAIL read_hselx: got %b expected 01", hselx);
        else pass_cnt++;
        tick();
        htrans = IDLE;
        haddr  = 32'hFFFF_0000;
        #1;
        total++;
        if (hrdata !== 32'hDEAD_BEEF)
            $display("FAIL read_hrdata: got %h expected deadbeef", hrdata);
        else pass_cnt++;
        total++;
        if (hready !== 1'b1 || hresp !== 1'b0)
            $display("FAIL read_resp: got %b%b expected 10", hready, hresp);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_gap();
        haddr  = 32'h0000_1004;
        htrans = NONSEQ;
        #1;
        total++;
        if (hselx !== 2'b00) $display("FAIL gap_hselx: got %b expected 00", hselx);
        else pass_cnt++;
        tick();
        htrans = IDLE;
        haddr  = 32'h0000_0000;
        #1;
        total++;
        if (hready !== 1'b0 || hresp !== 1'b1)
            $display("FAIL gap_err1: got %b%b expected 01", hready, hresp);
        else pass_cnt++;
        total++;
        if (hrdata !== 32'h0) $display("FAIL gap_hrdata: got %h expected 0", hrdata);
        else pass_cnt++;
        tick();
        total++;
        if (hready !== 1'b1 || hresp !== 1'b1)
            $display("FAIL gap_err2: got %b%b expected 11", hready, hresp);
        else pass_cnt++;
        tick();
        total++;
        if (hready !== 1'b1 || hresp !== 1'b0)
            $display("FAIL gap_done: got %b%b expected 10", hready, hresp);
        else pass_cnt++;
    endtask

    task automatic test_wait_states();
        haddr  = 32'h0000_2000;
        htrans = NONSEQ;
        tick();
        hreadyout_s[1]  = 1'b0;
        hrdata_s[31:0]  = 32'hCAFE_0000;
        haddr           = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (hready !== 1'b0 || hresp !== 1'b0)
                $display("FAIL wait_stall%0d: got %b%b expected 00", i, hready, hresp);
            else pass_cnt++;
            total++;
            if (hselx !== 2'b01)
                $display("FAIL wait_hselx%0d: got %b expected 01", i, hselx);
            else pass_cnt++;
            tick();
        end
        hreadyout_s[1]  = 1'b1;
        hrdata_s[63:32] = 32'h1234_5678;
        #1;
        total++;
        if (hready !== 1'b1 || hrdata !== 32'h1234_5678)
            $display("FAIL wait_s1_done: got %b %h expected 1 12345678", hready, hrdata);
        else pass_cnt++;
        tick();
        htrans = IDLE;
        #1;
        total++;
        if (hready !== 1'b1 || hrdata !== 32'hCAFE_0000)
            $display("FAIL wait_s0_nobubble: got %b %h expected 1 cafe0000", hready, hrdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_idle_unmapped();
        htrans = IDLE;
        haddr  = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (hready !== 1'b1 || hresp !== 1'b0 || hselx !== 2'b00)
                $display("FAIL idle_unmapped%0d: got %b%b %b expected 10 00",
                         i, hready, hresp, hselx);
            else pass_cnt++;
        end
        htrans = 2'b01;
        tick();
        total++;
        if (hready !== 1'b1 || hresp !== 1'b0)
            $display("FAIL busy_unmapped: got %b%b expected 10", hready, hresp);
        else pass_cnt++;
        htrans = IDLE;
    endtask

    task automatic test_slave_error();
        haddr      = 32'h0000_0100;
        htrans     = NONSEQ;
        hresp_s[0] = 1'b1;
        tick();
        htrans = IDLE;
        #1;
        total++;
        if (hresp !== 1'b1 || hready !== 1'b1)
            $display("FAIL slave_err: got %b%b expected 11", hready, hresp);
        else pass_cnt++;
        hresp_s[0] = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        haddr  = 32'h0000_1004;
        htrans = NONSEQ;
        tick();
        haddr = 32'h0000_3000;
        #1;
        total++;
        if (hready !== 1'b0 || hresp !== 1'b1)
            $display("FAIL b2b_err1a: got %b%b expected 01", hready, hresp);
        else pass_cnt++;
        tick();
        total++;
        if (hready !== 1'b1 || hresp !== 1'b1)
            $display("FAIL b2b_err2a: got %b%b expected 11", hready, hresp);
        else pass_cnt++;
        tick();
        htrans = IDLE;
        #1;
        total++;
        if (hready !== 1'b0 || hresp !== 1'b1)
            $display("FAIL b2b_err1b: got %b%b expected 01", hready, hresp);
        else pass_cnt++;
        tick();
        total++;
        if (hready !== 1'b1 || hresp !== 1'b1)
            $display("FAIL b2b_err2b: got %b%b expected 11", hready, hresp);
        else pass_cnt++;
        tick();
        total++;
        if (hready !== 1'b1 || hresp !== 1'b0)
            $display("FAIL b2b_done: got %b%b expected 10", hready, hresp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_err();
        haddr  = 32'h0000_1004;
        htrans = NONSEQ;
        tick();
        htrans = IDLE;
        #1;
        total++;
        if (hready !== 1'b0) $display("FAIL rst_mid_err1: got %b expected 0", hready);
        else pass_cnt++;
        hresetn = 1'b0;
        tick();
        total++;
        if (hready !== 1'b1 || hresp !== 1'b0)
            $display("FAIL rst_mid_after: got %b%b expected 10", hready, hresp);
        else pass_cnt++;
        hresetn = 1'b1;
        tick();
    endtask

`ifdef AHB_DECODER_TIMEOUT_EN
    task automatic test_timeout();
        int pulses = 0;
        haddr  = 32'h0000_0000;
        htrans = NONSEQ;
        tick();
        hreadyout_s[0] = 1'b0;
        htrans         = IDLE;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (timeout === 1'b1) pulses++;
            total++;
            if (hready !== 1'b0)
                $display("FAIL to_stall%0d: got %b expected 0", i, hready);
            else pass_cnt++;
            tick();
        end
        total++;
        if (pulses !== 0) $display("FAIL to_early: got %0d expected 0", pulses);
        else pass_cnt++;
        total++;
        if (timeout !== 1'b1 || hready !== 1'b0 || hresp !== 1'b1)
            $display("FAIL to_fire: got %b %b%b expected 1 01", timeout, hready, hresp);
        else pass_cnt++;
        tick();
        total++;
        if (timeout !== 1'b0 || hready !== 1'b1 || hresp !== 1'b1)
            $display("FAIL to_err2: got %b %b%b expected 0 11", timeout, hready, hresp);
        else pass_cnt++;
        tick();
        total++;
        if (hready !== 1'b1 || hresp !== 1'b0)
            $display("FAIL to_done: got %b%b expected 10", hready, hresp);
        else pass_cnt++;
        hreadyout_s[0] = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_mapped_read();
        test_gap();
        test_wait_states();
        test_idle_unmapped();
        test_slave_error();
        test_back_to_back();
        test_reset_mid_err();
`ifdef AHB_DECODER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
